segre_mem_arbiter: RTL and testbench

//  Parametrised N-channel cache-line memory request arbiter between the L1 caches and main memory.

---
 rtl/segre_mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_segre_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_arbiter.sv
// N-channel cache-line request arbiter: per-channel request FIFOs, one memory transaction in flight.
// Build option: define SEGRE_ARB_FIXED_PRIO_EN for lowest-index-first grant instead of round-robin.
module segre_mem_arbiter #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned BUF_DEPTH  = 16,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                             clk_i,
    input  logic                             rsn_i,
    input  logic [NUM_CH-1:0]                req_valid_i,
    output logic [NUM_CH-1:0]                req_ready_o,
    input  logic [NUM_CH-1:0]                req_rd_i,
    input  logic [NUM_CH-1:0]                req_wr_i,
    input  logic [NUM_CH*ADDR_W-1:0]         req_addr_i,
    input  logic [NUM_CH*LINE_BYTES*8-1:0]   req_line_i,
    output logic [NUM_CH-1:0]                rsp_valid_o,
    output logic [LINE_BYTES*8-1:0]          rsp_line_o,
    output logic                             mem_req_valid_o,
    input  logic                             mem_req_ready_i,
    output logic                             mem_rd_o,
    output logic                             mem_wr_o,
    output logic [ADDR_W-1:0]                mem_addr_o,
    output logic [LINE_BYTES*8-1:0]          mem_line_o,
    input  logic                             mem_rsp_valid_i,
    input  logic [LINE_BYTES*8-1:0]          mem_rsp_line_i
);

    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned IDX_W  = $clog2(BUF_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned ENT_W  = 2 + ADDR_W + LINE_W;
    localparam logic [PTR_W-1:0] FULL_DIFF = PTR_W'(BUF_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d, grant_c;
    logic              any_c;
    int unsigned       idx;
`ifndef SEGRE_ARB_FIXED_PRIO_EN
    logic [CH_W-1:0]   rr_q, rr_d;
`endif

    logic [ENT_W-1:0]  fifo_q [NUM_CH][BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
    logic [NUM_CH-1:0] full_q, full_d, empty_c, push_c, pop_c;
    logic [ENT_W-1:0]  head_c;

    logic              mem_valid_q, mem_valid_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_line_q, mem_line_d;
    logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
    logic [LINE_W-1:0] rsp_line_q, rsp_line_d;

    // FIFO status; requests with neither rd nor wr are accepted but dropped
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            empty_c[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            push_c[c]  = req_valid_i[c] & ~full_q[c] & (req_rd_i[c] | req_wr_i[c]);
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push_c[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop_c[c]);
            full_d[c]   = ((wr_ptr_d[c] ^ rd_ptr_d[c]) == FULL_DIFF);
        end
    end

    // Entry layout {rd, wr, addr, line}; rd wins when both are set
    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (push_c[c]) begin
                fifo_q[c][wr_ptr_q[c][IDX_W-1:0]] <= {req_rd_i[c], req_wr_i[c] & ~req_rd_i[c],
                                                      req_addr_i[c*ADDR_W +: ADDR_W],
                                                      req_line_i[c*LINE_W +: LINE_W]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            full_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
            full_q <= full_d;
        end
    end

    assign head_c = fifo_q[grant_q][rd_ptr_q[grant_q][IDX_W-1:0]];

    // First non-empty channel in priority order
    always_comb begin
        any_c   = 1'b0;
        grant_c = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
`ifdef SEGRE_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (32'(rr_q) + k) % NUM_CH;
`endif
            if (!any_c && !empty_c[CH_W'(idx)]) begin
                any_c   = 1'b1;
                grant_c = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
`ifndef SEGRE_ARB_FIXED_PRIO_EN
        rr_d        = rr_q;
`endif
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_line_d  = mem_line_q;
        rsp_valid_d = '0;
        rsp_line_d  = rsp_line_q;
        pop_c       = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    grant_d = grant_c;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!mem_valid_q) begin
                    mem_valid_d = 1'b1;
                    {mem_rd_d, mem_wr_d, mem_addr_d, mem_line_d} = head_c;
                end else if (mem_req_ready_i) begin
                    mem_valid_d    = 1'b0;
                    mem_rd_d       = 1'b0;
                    mem_wr_d       = 1'b0;
                    pop_c[grant_q] = 1'b1;
                    state_d        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid_i) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_line_d           = mem_rsp_line_i;
`ifndef SEGRE_ARB_FIXED_PRIO_EN
                    rr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
`ifndef SEGRE_ARB_FIXED_PRIO_EN
            rr_q        <= '0;
`endif
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_line_q  <= '0;
            rsp_valid_q <= '0;
            rsp_line_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
`ifndef SEGRE_ARB_FIXED_PRIO_EN
            rr_q        <= rr_d;
`endif
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_line_q  <= mem_line_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_line_q  <= rsp_line_d;
        end
    end

    assign req_ready_o     = ~full_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_line_o      = rsp_line_q;
    assign mem_req_valid_o = mem_valid_q;
    assign mem_rd_o        = mem_rd_q;
    assign mem_wr_o        = mem_wr_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_line_o      = mem_line_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Self-checking bench for segre_mem_arbiter: transaction-level queue model plus directed literal checks.
module tb_segre_mem_arbiter;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
    localparam int LW     = 128;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LW-1:0]     line;
    } ent_t;

    logic                     clk, rsn;
    logic [NUM_CH-1:0]        req_valid, req_ready, req_rd, req_wr, rsp_valid;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*LW-1:0]     req_line;
    logic [LW-1:0]            rsp_line, mem_line, mem_rsp_line;
    logic                     mem_req_valid, mem_req_ready, mem_rd, mem_wr, mem_rsp_valid;
    logic [ADDR_W-1:0]        mem_addr;

    segre_mem_arbiter #(.NUM_CH(NUM_CH), .BUF_DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_BYTES(16)) dut (
        .clk_i(clk), .rsn_i(rsn),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rd_i(req_rd), .req_wr_i(req_wr),
        .req_addr_i(req_addr), .req_line_i(req_line),
        .rsp_valid_o(rsp_valid), .rsp_line_o(rsp_line),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_line_o(mem_line),
        .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_line_i(mem_rsp_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: per-channel circular queues and the phase of the single outstanding transaction
    ent_t              mbuf [NUM_CH][DEPTH];
    int                mcnt [NUM_CH];
    int                mhead[NUM_CH];
    int                ph, g, rr;
    logic              e_mvalid;
    ent_t              e_ent;
    logic [NUM_CH-1:0] e_rsp_valid;
    logic [LW-1:0]     e_rsp_line;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mcnt[c]  = 0;
            mhead[c] = 0;
        end
        ph = 0; g = 0; rr = 0;
        e_mvalid = 1'b0; e_ent = '0; e_rsp_valid = '0; e_rsp_line = '0;
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] pre_ready;
        logic              found, do_pop;
        int                c, slot;
        if (!rsn) return;
        for (int k = 0; k < NUM_CH; k++) pre_ready[k] = (mcnt[k] < DEPTH);
        e_rsp_valid = '0;
        do_pop = 1'b0;
        found = 1'b0;
        if (ph == 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef SEGRE_ARB_FIXED_PRIO_EN
                c = k;
`else
                c = (rr + k) % NUM_CH;
`endif
                if (!found && mcnt[c] > 0) begin
                    found = 1'b1; g = c; ph = 1;
                end
            end
        end else if (ph == 1) begin
            ph = 2; e_mvalid = 1'b1; e_ent = mbuf[g][mhead[g]];
        end else if (ph == 2) begin
            if (mem_req_ready) begin ph = 3; e_mvalid = 1'b0; do_pop = 1'b1; end
        end else begin
            if (mem_rsp_valid) begin
                e_rsp_valid[g] = 1'b1; e_rsp_line = mem_rsp_line; rr = (g + 1) % NUM_CH; ph = 0;
            end
        end
        if (do_pop) begin
            mhead[g] = (mhead[g] + 1) % DEPTH;
            mcnt[g]  = mcnt[g] - 1;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (req_valid[k] && pre_ready[k] && (req_rd[k] || req_wr[k])) begin
                slot = (mhead[k] + mcnt[k]) % DEPTH;
                mbuf[k][slot].rd   = req_rd[k];
                mbuf[k][slot].wr   = req_wr[k] & ~req_rd[k];
                mbuf[k][slot].addr = req_addr[k*ADDR_W +: ADDR_W];
                mbuf[k][slot].line = req_line[k*LW +: LW];
                mcnt[k] = mcnt[k] + 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] er;
        for (int k = 0; k < NUM_CH; k++) er[k] = (mcnt[k] < DEPTH);
        chk("req_ready", LW'(req_ready), LW'(er));
        chk("mem_req_valid", LW'(mem_req_valid), LW'(e_mvalid));
        if (e_mvalid) begin
            chk("mem_rd", LW'(mem_rd), LW'(e_ent.rd));
            chk("mem_wr", LW'(mem_wr), LW'(e_ent.wr));
            chk("mem_addr", LW'(mem_addr), LW'(e_ent.addr));
            chk("mem_line", mem_line, e_ent.line);
        end
        chk("rsp_valid", LW'(rsp_valid), LW'(e_rsp_valid));
        chk("rsp_line", rsp_line, e_rsp_line);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clr_req();
        req_valid = '0; req_rd = '0; req_wr = '0;
    endtask

    task automatic set_req(input int c, input logic rd, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [LW-1:0] l);
        req_valid[c] = 1'b1; req_rd[c] = rd; req_wr[c] = wr;
        req_addr[c*ADDR_W +: ADDR_W] = a;
        req_line[c*LW +: LW] = l;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rsn = 1'b0;
        clr_req();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_line = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rsn = 1'b1;
    endtask

    logic [ADDR_W-1:0] obs [8];
    logic [ADDR_W-1:0] exp_order [6];
    logic [LW-1:0]     pat;
    int                nhs;
    logic              hs_rd, hs_wr;

    initial begin
        rsn = 1'b1;
        clr_req();
        req_addr = '0; req_line = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_line = '0;
        model_reset();
        #2 rsn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset req_ready", LW'(req_ready), LW'(2'b11));
        chk("reset mem_req_valid", LW'(mem_req_valid), '0);
        chk("reset mem_rd_wr", LW'({mem_rd, mem_wr}), '0);
        chk("reset mem_addr", LW'(mem_addr), '0);
        chk("reset mem_line", mem_line, '0);
        chk("reset rsp_valid", LW'(rsp_valid), '0);
        chk("reset rsp_line", rsp_line, '0);
        rsn = 1'b1;

        // Single read: request visible two edges after the push, response to ch0
        mem_req_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h100, '0);
        step();
        clr_req();
        step();
        chk("t1 valid early", LW'(mem_req_valid), '0);
        step();
        chk("t1 valid", LW'(mem_req_valid), LW'(1'b1));
        chk("t1 addr", LW'(mem_addr), LW'(32'h100));
        chk("t1 rd", LW'(mem_rd), LW'(1'b1));
        step();
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_line  = {16{8'hAA}};
        step();
        mem_rsp_valid = 1'b0;
        chk("t1 rsp_valid", LW'(rsp_valid), LW'(2'b01));
        chk("t1 rsp_line", rsp_line, {16{8'hAA}});
        step();
        chk("t1 rsp pulse", LW'(rsp_valid), '0);

        // Both channels push three reads together; check issue order
        reset_dut();
`ifdef SEGRE_ARB_FIXED_PRIO_EN
        exp_order[0] = 32'h1000; exp_order[1] = 32'h1004; exp_order[2] = 32'h1008;
        exp_order[3] = 32'h2000; exp_order[4] = 32'h2004; exp_order[5] = 32'h2008;
`else
        exp_order[0] = 32'h1000; exp_order[1] = 32'h2000; exp_order[2] = 32'h1004;
        exp_order[3] = 32'h2004; exp_order[4] = 32'h1008; exp_order[5] = 32'h2008;
`endif
        for (int i = 0; i < 8; i++) obs[i] = '1;
        nhs = 0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_line = {4{$urandom}};
        for (int i = 0; i < 40; i++) begin
            if (i < 3) begin
                set_req(0, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), {4{$urandom}});
                set_req(1, 1'b1, 1'b0, 32'h2000 + 32'(i * 4), {4{$urandom}});
            end else begin
                clr_req();
            end
            step();
            if (mem_req_valid && mem_req_ready && nhs < 8) begin
                obs[nhs] = mem_addr;
                nhs++;
            end
        end
        for (int i = 0; i < 6; i++) chk("t2 order", LW'(obs[i]), LW'(exp_order[i]));
        chk("t2 count", LW'(nhs), LW'(6));

        // Write stalled by memory: outputs held, ack routed to ch1
        reset_dut();
        pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        set_req(1, 1'b0, 1'b1, 32'h200, pat);
        step();
        clr_req();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3 valid", LW'(mem_req_valid), LW'(1'b1));
            chk("t3 addr", LW'(mem_addr), LW'(32'h200));
            chk("t3 wr", LW'({mem_rd, mem_wr}), LW'(2'b01));
            chk("t3 line", mem_line, pat);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        chk("t3 ack", LW'(rsp_valid), LW'(2'b10));

        // Fill ch0 to depth with memory stalled
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            set_req(0, 1'b1, 1'b0, 32'h3000 + 32'(i * 16), {4{$urandom}});
            step();
            chk("t4 ready", LW'(req_ready[0]), LW'(i < DEPTH - 1));
        end
        set_req(0, 1'b1, 1'b0, 32'hDEAD_0000, '0);
        step();
        chk("t4 full", LW'(req_ready[0]), '0);
        clr_req();
        mem_req_ready = 1'b1;
        step();
        chk("t4 ready after pop", LW'(req_ready[0]), LW'(1'b1));
        mem_rsp_valid = 1'b1;
        nhs = 0;
        obs[0] = '0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (mem_req_valid && mem_req_ready) begin
                obs[0] = mem_addr;
                nhs++;
            end
        end
        chk("t4 drained", LW'(nhs), LW'(DEPTH - 1));
        chk("t4 last addr", LW'(obs[0]), LW'(32'h30F0));

        // rd=wr=1 issues as read; rd=wr=0 is dropped
        reset_dut();
        set_req(0, 1'b1, 1'b1, 32'h300, {4{$urandom}});
        set_req(1, 1'b0, 1'b0, 32'h400, {4{$urandom}});
        step();
        clr_req();
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        nhs = 0; obs[0] = '0; hs_rd = 1'b0; hs_wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req_valid && mem_req_ready) begin
                obs[0] = mem_addr; hs_rd = mem_rd; hs_wr = mem_wr;
                nhs++;
            end
        end
        chk("t5 count", LW'(nhs), LW'(1));
        chk("t5 addr", LW'(obs[0]), LW'(32'h300));
        chk("t5 rd_wr", LW'({hs_rd, hs_wr}), LW'(2'b10));

        // Reset while waiting for the response; late response ignored
        reset_dut();
        mem_req_ready = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h500, {4{$urandom}});
        step();
        clr_req();
        repeat (3) step();
        rsn = 1'b0;
        model_reset();
        #1;
        chk("t6 mem_req_valid", LW'(mem_req_valid), '0);
        chk("t6 req_ready", LW'(req_ready), LW'(2'b11));
        chk("t6 mem_addr", LW'(mem_addr), '0);
        mem_rsp_valid = 1'b1;
        mem_rsp_line  = {4{$urandom}};
        step();
        rsn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6 no rsp", LW'(rsp_valid), '0);
            chk("t6 line", rsp_line, '0);
        end
        mem_rsp_valid = 1'b0;

        // Random traffic against the model with varying memory back-pressure
        reset_dut();
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    req_valid[c] = ($urandom_range(0, 2) != 0);
                    req_rd[c]    = 1'($urandom);
                    req_wr[c]    = 1'($urandom);
                    req_addr[c*ADDR_W +: ADDR_W] = $urandom;
                    req_line[c*LW +: LW] = {$urandom, $urandom, $urandom, $urandom};
                end
                mem_req_ready = ($urandom_range(0, 9) < 2 + blk);
                mem_rsp_valid = ($urandom_range(0, 9) < 4);
                mem_rsp_line  = {$urandom, $urandom, $urandom, $urandom};
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
